mux_key_cam: RTL and testbench

Writable, registered successor to the combinational key/data lookup mux. It holds NR_KEY {valid, key, data} entries that are written at run time and looked up through a valid/ready request/response pipe with 1-cycle latency. It resolves multiple matches by priority, reports hit and index, and supports invalidate, flush and round-robin replacement. It sits beside decode/CSR/small-cache logic wherever a runtime-programmable key→data map is needed.

---
 rtl/mux_key_pkg.sv | 12 +
 rtl/mux_key_match.sv | 28 ++
 rtl/mux_key_cam.sv | 180 ++++++++++++++++++
 tb/tb_mux_key_cam.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_key_pkg.sv
// Shared width helpers for the writable key/data lookup table.
package mux_key_pkg;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mux_key_match.sv
// Combinational key compare across all entries with lowest-index priority.
module mux_key_match
  import mux_key_pkg::*;
#(
  parameter int NR_KEY  = 8,
  parameter int KEY_LEN = 8,
  localparam int IDX_W  = idx_w(NR_KEY)
) (
  input  logic [NR_KEY-1:0]              valid,
  input  logic [NR_KEY-1:0][KEY_LEN-1:0] keys,
  input  logic [KEY_LEN-1:0]             key,
  output logic                           hit,
  output logic [IDX_W-1:0]               idx
);

  // Scan downward so the lowest matching index is the last one assigned.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (valid[i] && (keys[i] == key)) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/mux_key_cam.sv
// Runtime-writable key->data table with a 1-cycle registered lookup pipe,
// in-place update, lowest-free allocation and round-robin replacement.
module mux_key_cam
  import mux_key_pkg::*;
#(
  parameter int NR_KEY      = 8,
  parameter int KEY_LEN     = 8,
  parameter int DATA_LEN    = 32,
  parameter int HAS_DEFAULT = 1,
  localparam int IDX_W      = idx_w(NR_KEY),
  localparam int CNT_W      = cnt_w(NR_KEY)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic                inv_en,
  input  logic [KEY_LEN-1:0]  inv_key,
  input  logic                flush,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [KEY_LEN-1:0]  req_key,
  input  logic [DATA_LEN-1:0] default_out,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_hit,
  output logic [DATA_LEN-1:0] rsp_data,
  output logic [IDX_W-1:0]    rsp_idx,
  output logic [CNT_W-1:0]    count,
  output logic                full
);

  logic [NR_KEY-1:0]               valid_q;
  logic [NR_KEY-1:0][KEY_LEN-1:0]  key_q;
  logic [NR_KEY-1:0][DATA_LEN-1:0] data_q;
  logic [IDX_W-1:0]                victim_q;
  logic [CNT_W-1:0]                count_q;
  logic                            full_q;

  logic                            vld_p1;
  logic                            hit_p1;
  logic [DATA_LEN-1:0]             data_p1;
  logic [IDX_W-1:0]                idx_p1;

  logic                            lk_hit;
  logic [IDX_W-1:0]                lk_idx;
  logic [DATA_LEN-1:0]             lk_data;
  logic                            wr_hit;
  logic [IDX_W-1:0]                wr_idx;
  logic                            inv_hit;
  logic [IDX_W-1:0]                inv_idx;

  logic [IDX_W-1:0]                free_idx;
  logic                            wr_cancel;
  logic                            wr_apply;
  logic                            replace;
  logic [IDX_W-1:0]                wr_slot;
  logic [NR_KEY-1:0]               valid_n;
  logic [IDX_W-1:0]                victim_n;
  logic [CNT_W-1:0]                count_n;
  logic                            req_fire;

  function automatic logic [CNT_W-1:0] popcount(input logic [NR_KEY-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  mux_key_match #(.NR_KEY(NR_KEY), .KEY_LEN(KEY_LEN)) u_lookup (
    .valid (valid_q),
    .keys  (key_q),
    .key   (req_key),
    .hit   (lk_hit),
    .idx   (lk_idx)
  );

  mux_key_match #(.NR_KEY(NR_KEY), .KEY_LEN(KEY_LEN)) u_write (
    .valid (valid_q),
    .keys  (key_q),
    .key   (wr_key),
    .hit   (wr_hit),
    .idx   (wr_idx)
  );

  mux_key_match #(.NR_KEY(NR_KEY), .KEY_LEN(KEY_LEN)) u_inv (
    .valid (valid_q),
    .keys  (key_q),
    .key   (inv_key),
    .hit   (inv_hit),
    .idx   (inv_idx)
  );

  always_comb begin
    free_idx = '0;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

  // A write racing an invalidate of the same key is dropped so the key ends absent.
  assign wr_cancel = inv_en && (inv_key == wr_key);
  assign wr_apply  = wr_en && !wr_cancel && !flush;
  assign replace   = wr_apply && !wr_hit && full_q;
  assign wr_slot   = wr_hit ? wr_idx : (full_q ? victim_q : free_idx);

  always_comb begin
    valid_n = valid_q;
    if (flush) begin
      valid_n = '0;
    end else begin
      if (inv_en && inv_hit) valid_n[inv_idx] = 1'b0;
      if (wr_apply)          valid_n[wr_slot] = 1'b1;
    end
  end

  always_comb begin
    victim_n = victim_q;
    if (flush) begin
      victim_n = '0;
    end else if (replace) begin
      victim_n = (victim_q == IDX_W'(NR_KEY - 1)) ? '0 : victim_q + IDX_W'(1);
    end
  end

  assign count_n   = popcount(valid_n);
  assign req_ready = !vld_p1 || rsp_ready;
  assign req_fire  = req_valid && req_ready;
  assign lk_data   = lk_hit ? data_q[lk_idx]
                            : ((HAS_DEFAULT != 0) ? default_out : '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q  <= '0;
      victim_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      valid_q  <= valid_n;
      victim_q <= victim_n;
      count_q  <= count_n;
      full_q   <= (count_n == CNT_W'(NR_KEY));
    end
  end

  always_ff @(posedge clock) begin
    if (wr_apply) begin
      key_q[wr_slot]  <= wr_key;
      data_q[wr_slot] <= wr_data;
    end
  end

  // p0 -> p1: lookup result registered; held while the consumer stalls.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      hit_p1  <= 1'b0;
      data_p1 <= '0;
      idx_p1  <= '0;
    end else if (req_fire) begin
      vld_p1  <= 1'b1;
      hit_p1  <= lk_hit;
      data_p1 <= lk_data;
      idx_p1  <= lk_idx;
    end else if (rsp_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign rsp_valid = vld_p1;
  assign rsp_hit   = hit_p1;
  assign rsp_data  = data_p1;
  assign rsp_idx   = idx_p1;
  assign count     = count_q;
  assign full      = full_q;

endmodule

// File: tb/tb_mux_key_cam.sv
// Bench for mux_key_cam: table-level model plus directed literal checks.
module tb_mux_key_cam;
  localparam int NR = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0, inv_en = 1'b0, flush = 1'b0;
  logic [7:0]  wr_key = '0, inv_key = '0, req_key = '0;
  logic [31:0] wr_data = '0, default_out = 32'hDEAD;
  logic        req_valid = 1'b0, rsp_ready = 1'b1;

  logic        req_ready, rsp_valid, rsp_hit, full;
  logic [31:0] rsp_data;
  logic [2:0]  rsp_idx;
  logic [3:0]  count;
  logic        req_ready_z, rsp_valid_z, rsp_hit_z, full_z;
  logic [31:0] rsp_data_z;
  logic [2:0]  rsp_idx_z;
  logic [3:0]  count_z;

  int n_chk = 0;
  int n_fail = 0;

  // model state
  bit          m_v[NR];
  logic [7:0]  m_k[NR];
  logic [31:0] m_d[NR];
  int          m_vic;
  bit          e_vld, e_hit;
  int          e_idx;
  logic [31:0] e_d1, e_d0;

  always #5 clock = ~clock;

  mux_key_cam #(.NR_KEY(NR), .KEY_LEN(8), .DATA_LEN(32), .HAS_DEFAULT(1)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_key(wr_key), .wr_data(wr_data),
    .inv_en(inv_en), .inv_key(inv_key), .flush(flush), .req_valid(req_valid),
    .req_ready(req_ready), .req_key(req_key), .default_out(default_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
    .rsp_data(rsp_data), .rsp_idx(rsp_idx), .count(count), .full(full)
  );

  mux_key_cam #(.NR_KEY(NR), .KEY_LEN(8), .DATA_LEN(32), .HAS_DEFAULT(0)) dut0 (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_key(wr_key), .wr_data(wr_data),
    .inv_en(inv_en), .inv_key(inv_key), .flush(flush), .req_valid(req_valid),
    .req_ready(req_ready_z), .req_key(req_key), .default_out(default_out),
    .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit_z),
    .rsp_data(rsp_data_z), .rsp_idx(rsp_idx_z), .count(count_z), .full(full_z)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int find(input logic [7:0] k);
    for (int i = 0; i < NR; i++) if (m_v[i] && m_k[i] == k) return i;
    return -1;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NR; i++) if (m_v[i]) c++;
    return c;
  endfunction

  function automatic int first_free();
    for (int i = 0; i < NR; i++) if (!m_v[i]) return i;
    return -1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NR; i++) m_v[i] = 1'b0;
    m_vic = 0;
    e_vld = 1'b0; e_hit = 1'b0; e_idx = 0; e_d1 = '0; e_d0 = '0;
  endtask

  // One clock: evaluate the table rules on the pre-edge state, then commit.
  task automatic cyc();
    bit nv[NR];
    logic [7:0] nk[NR];
    logic [31:0] nd[NR];
    int nvic, ii, slot, li;
    bit n_vld, n_hit;
    int n_idx;
    logic [31:0] n_d1, n_d0;
    nv = m_v; nk = m_k; nd = m_d; nvic = m_vic;
    n_vld = e_vld; n_hit = e_hit; n_idx = e_idx; n_d1 = e_d1; n_d0 = e_d0;
    if (req_valid && (!e_vld || rsp_ready)) begin
      li = find(req_key);
      n_vld = 1'b1;
      n_hit = (li >= 0);
      n_idx = (li >= 0) ? li : 0;
      n_d1  = (li >= 0) ? m_d[li] : default_out;
      n_d0  = (li >= 0) ? m_d[li] : 32'h0;
    end else if (rsp_ready) begin
      n_vld = 1'b0;
    end
    if (flush) begin
      for (int i = 0; i < NR; i++) nv[i] = 1'b0;
      nvic = 0;
    end else begin
      ii = inv_en ? find(inv_key) : -1;
      if (ii >= 0) nv[ii] = 1'b0;
      if (wr_en && !(inv_en && inv_key == wr_key)) begin
        slot = find(wr_key);
        if (slot < 0) begin
          if (m_count() < NR) slot = first_free();
          else begin
            slot = m_vic;
            nvic = (m_vic + 1) % NR;
          end
        end
        nv[slot] = 1'b1; nk[slot] = wr_key; nd[slot] = wr_data;
      end
    end
    @(posedge clock);
    #1;
    m_v = nv; m_k = nk; m_d = nd; m_vic = nvic;
    e_vld = n_vld; e_hit = n_hit; e_idx = n_idx; e_d1 = n_d1; e_d0 = n_d0;
    wr_en = 1'b0; inv_en = 1'b0; flush = 1'b0; req_valid = 1'b0;
  endtask

  task automatic wr(input logic [7:0] k, input logic [31:0] d);
    wr_en = 1'b1; wr_key = k; wr_data = d;
    cyc();
  endtask

  task automatic look(input logic [7:0] k);
    req_valid = 1'b1; req_key = k;
    cyc();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      chk("count", 64'(count), 64'(m_count()));
      chk("full", 64'(full), 64'(m_count() == NR));
      chk("req_ready", 64'(req_ready), 64'(!e_vld || rsp_ready));
      chk("rsp_valid", 64'(rsp_valid), 64'(e_vld));
      chk("z_rsp_valid", 64'(rsp_valid_z), 64'(e_vld));
      chk("z_count", 64'(count_z), 64'(m_count()));
      chk("z_full", 64'(full_z), 64'(m_count() == NR));
      chk("z_req_ready", 64'(req_ready_z), 64'(!e_vld || rsp_ready));
      if (e_vld) begin
        chk("rsp_hit", 64'(rsp_hit), 64'(e_hit));
        chk("rsp_idx", 64'(rsp_idx), 64'(e_idx));
        chk("rsp_data", 64'(rsp_data), 64'(e_d1));
        chk("z_rsp_hit", 64'(rsp_hit_z), 64'(e_hit));
        chk("z_rsp_idx", 64'(rsp_idx_z), 64'(e_idx));
        chk("z_rsp_data", 64'(rsp_data_z), 64'(e_d0));
      end
    end
  end

  initial begin
    apply_reset();
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_count", 64'(count), 64'h0);
    chk("rst_full", 64'(full), 64'h0);
    chk("rst_req_ready", 64'(req_ready), 64'h1);

    // basic write and lookup
    wr(8'h10, 32'hAAAA0001);
    wr(8'h20, 32'hAAAA0002);
    look(8'h20);
    chk("t1_hit", 64'(rsp_hit), 64'h1);
    chk("t1_data", 64'(rsp_data), 64'hAAAA0002);
    chk("t1_idx", 64'(rsp_idx), 64'h1);
    chk("t1_count", 64'(count), 64'h2);

    // miss with and without default
    look(8'h33);
    chk("t2_hit", 64'(rsp_hit), 64'h0);
    chk("t2_data", 64'(rsp_data), 64'hDEAD);
    chk("t2_idx", 64'(rsp_idx), 64'h0);
    chk("t2_z_data", 64'(rsp_data_z), 64'h0);
    cyc();

    // stall: response holds while the table changes underneath
    rsp_ready = 1'b0;
    look(8'h20);
    for (int s = 0; s < 3; s++) begin
      if (s == 0) begin
        wr_en = 1'b1; wr_key = 8'h20; wr_data = 32'hBBBB0002;
      end
      req_valid = 1'b1; req_key = 8'h10;
      cyc();
      chk("t4_valid", 64'(rsp_valid), 64'h1);
      chk("t4_ready", 64'(req_ready), 64'h0);
      chk("t4_data", 64'(rsp_data), 64'hAAAA0002);
      chk("t4_idx", 64'(rsp_idx), 64'h1);
    end
    rsp_ready = 1'b1;
    look(8'h20);
    chk("t4_new_data", 64'(rsp_data), 64'hBBBB0002);
    cyc();

    // simultaneous write/invalidate/flush
    wr_en = 1'b1; wr_key = 8'h40; wr_data = 32'h4040;
    inv_en = 1'b1; inv_key = 8'h40;
    cyc();
    chk("t5_eq_count", 64'(count), 64'h2);
    wr_en = 1'b1; wr_key = 8'h41; wr_data = 32'hCCCC0041;
    inv_en = 1'b1; inv_key = 8'h10;
    req_valid = 1'b1; req_key = 8'h40;
    cyc();
    chk("t5_40_miss", 64'(rsp_hit), 64'h0);
    chk("t5_net_count", 64'(count), 64'h2);
    look(8'h41);
    chk("t5_41_idx", 64'(rsp_idx), 64'h2);
    chk("t5_41_data", 64'(rsp_data), 64'hCCCC0041);
    look(8'h10);
    chk("t5_10_miss", 64'(rsp_hit), 64'h0);
    flush = 1'b1; wr_en = 1'b1; wr_key = 8'h55; wr_data = 32'h55;
    req_valid = 1'b1; req_key = 8'h20;
    cyc();
    chk("t5_flush_count", 64'(count), 64'h0);
    chk("t5_pre_flush_hit", 64'(rsp_hit), 64'h1);
    look(8'h20);
    chk("t5_post_flush_miss", 64'(rsp_hit), 64'h0);

    // fill, then round-robin replacement
    for (int k = 0; k < NR; k++) wr(8'(k), 32'h1000 + k);
    chk("t3_full", 64'(full), 64'h1);
    chk("t3_count", 64'(count), 64'h8);
    wr(8'h08, 32'h2008);
    wr(8'h09, 32'h2009);
    chk("t3_full2", 64'(full), 64'h1);
    chk("t3_count2", 64'(count), 64'h8);
    look(8'h08);
    chk("t3_8_idx", 64'(rsp_idx), 64'h0);
    look(8'h09);
    chk("t3_9_idx", 64'(rsp_idx), 64'h1);
    look(8'h00);
    chk("t3_0_miss", 64'(rsp_hit), 64'h0);
    wr(8'h0A, 32'h200A);
    look(8'h0A);
    chk("t3_10_idx", 64'(rsp_idx), 64'h2);
    look(8'h02);
    chk("t3_2_miss", 64'(rsp_hit), 64'h0);
    look(8'h07);
    chk("t3_7_data", 64'(rsp_data), 64'h1007);

    // asynchronous reset with a response pending
    look(8'h03);
    chk("t6_pre_valid", 64'(rsp_valid), 64'h1);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_valid", 64'(rsp_valid), 64'h0);
    chk("t6_async_count", 64'(count), 64'h0);
    chk("t6_async_full", 64'(full), 64'h0);
    apply_reset();
    default_out = 32'h1234BEEF;
    look(8'h03);
    chk("t6_3_miss", 64'(rsp_hit), 64'h0);
    chk("t6_3_default", 64'(rsp_data), 64'h1234BEEF);
    look(8'h08);
    chk("t6_8_miss", 64'(rsp_hit), 64'h0);
    look(8'h0A);
    chk("t6_10_miss", 64'(rsp_hit), 64'h0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
